aes_job_scheduler: RTL

AES_JOB_SCHEDULER -- requirements
Module: aes_job_scheduler

---
 rtl/aes_job_scheduler.sv | 105 ++++++++++
 1 files changed

// File: rtl/aes_job_scheduler.sv
// Two-requester job scheduler for a fixed-latency AES128 core: one job in flight,
// round-robin on contention, response held until the consumer accepts it.
module aes_job_scheduler #(
    parameter int unsigned CORE_LATENCY = 12,
    parameter int unsigned CNT_W        = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [1:0]       req_valid,
    output logic [1:0]       req_ready,
    input  logic [127:0]     req0_data,
    input  logic [127:0]     req1_data,
    input  logic [127:0]     req0_key,
    input  logic [127:0]     req1_key,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [127:0]     rsp_data,
    output logic             rsp_id,
    output logic [127:0]     core_data,
    output logic [127:0]     core_key,
    input  logic [127:0]     core_result,
    output logic             busy,
    output logic [CNT_W-1:0] job_count
);

    typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

    localparam logic [7:0] LAT_LOAD = 8'(CORE_LATENCY - 1);

    state_t     state;
    state_t     state_nxt;
    logic       prio;
    logic [7:0] cnt;
    logic       grant_id;
    logic       req_fire;
    logic       rsp_fire;

    // Grant is only offered to a valid requester, so any ready bit is a handshake.
    always_comb begin
        req_ready = '0;
        if (state == IDLE && reset) begin
            case (req_valid)
                2'b01:   req_ready = 2'b01;
                2'b10:   req_ready = 2'b10;
                2'b11:   req_ready = prio ? 2'b10 : 2'b01;
                default: req_ready = '0;
            endcase
        end
    end

    assign grant_id  = req_ready[1];
    assign req_fire  = |req_ready;
    assign rsp_valid = (state == DONE);
    assign rsp_fire  = rsp_valid && rsp_ready;
    assign busy      = (state != IDLE);

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (req_fire) state_nxt = WAIT;
            WAIT:    if (cnt == '0) state_nxt = DONE;
            DONE:    if (rsp_fire) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            prio      <= 1'b0;
            cnt       <= '0;
            rsp_data  <= '0;
            rsp_id    <= 1'b0;
            core_data <= '0;
            core_key  <= '0;
            job_count <= '0;
        end else begin
            if (req_fire) begin
                core_data <= grant_id ? req1_data : req0_data;
                core_key  <= grant_id ? req1_key  : req0_key;
                rsp_id    <= grant_id;
                prio      <= ~grant_id;
                cnt       <= LAT_LOAD;
            end
            if (state == WAIT) begin
                if (cnt == '0) begin
                    rsp_data <= core_result;
                end else begin
                    cnt <= cnt - 8'd1;
                end
            end
            if (rsp_fire) begin
                job_count <= job_count + 1'b1;
            end
        end
    end

endmodule
